// File: rtl/comm_tx_scheduler_if.sv
// Bundles the source request lanes and the UART byte handshake of comm_tx_scheduler.
// The scheduler uses the slave modport; producers and the transmitter side use master.
interface comm_tx_scheduler_if #(
    parameter int NUM_SRC = 3
);
    logic [NUM_SRC-1:0]     src_valid;
    logic [32*NUM_SRC-1:0]  src_data;
    logic [4*NUM_SRC-1:0]   src_digits;
    logic [8*NUM_SRC-1:0]   src_prefix;
    logic [NUM_SRC-1:0]     src_ack;
    logic                   uart_tx_new_byte;
    logic [7:0]             uart_tx_byte;
    logic                   uart_tx_ready;

    modport master (
        output src_valid,
        output src_data,
        output src_digits,
        output src_prefix,
        input  src_ack,
        input  uart_tx_new_byte,
        input  uart_tx_byte,
        output uart_tx_ready
    );

    modport slave (
        input  src_valid,
        input  src_data,
        input  src_digits,
        input  src_prefix,
        output src_ack,
        output uart_tx_new_byte,
        output uart_tx_byte,
        input  uart_tx_ready
    );
endinterface

// File: rtl/comm_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmitter between report sources and
// serialises each granted word as one ASCII line: [prefix] hex digits MSB-first, 0x0A.
module comm_tx_scheduler #(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    comm_tx_scheduler_if.slave    bus,
    output logic                  busy,
    output logic [IDX_W-1:0]      grant_idx
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFIX  = 2'd1,
        DIGITS  = 2'd2,
        NEWLINE = 2'd3
    } state_t;

    state_t             state_reg;
    logic [31:0]        word_reg;
    logic [7:0]         prefix_reg;
    logic [3:0]         count_reg;
    logic               hold_reg;
    logic [NUM_SRC-1:0] ack_reg;
    logic               new_byte_reg;
    logic [7:0]         byte_reg;
    logic               busy_reg;
    logic [IDX_W-1:0]   grant_reg;

    logic [31:0]        data_arr   [NUM_SRC];
    logic [3:0]         digits_arr [NUM_SRC];
    logic [7:0]         prefix_arr [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slice
        assign data_arr[gi]   = bus.src_data[32*gi +: 32];
        assign digits_arr[gi] = bus.src_digits[4*gi +: 4];
        assign prefix_arr[gi] = bus.src_prefix[8*gi +: 8];
    end

    // Search downward in distance from the last grant so the nearest pending
    // source after grant_reg is the one left standing.
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    int                 cand_sum;
    logic [IDX_W-1:0]   cand_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = 0;
        cand_idx  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand_sum = int'(grant_reg) + k;
            if (cand_sum >= NUM_SRC) begin
                cand_sum = cand_sum - NUM_SRC;
            end
            cand_idx = IDX_W'(cand_sum);
            if (bus.src_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    logic [3:0]         sel_digits;
    logic [3:0]         sel_count;
    logic [5:0]         shift_amt;
    logic [31:0]        sel_word;

    always_comb begin
        sel_digits = digits_arr[win_idx];
        sel_count  = (sel_digits == 4'd0 || sel_digits > 4'd8) ? 4'd8 : sel_digits;
        shift_amt  = {4'd8 - sel_count, 2'b00};
        sel_word   = data_arr[win_idx] << shift_amt;
    end

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? ({4'h0, nib} + 8'h30) : ({4'h0, nib} + 8'h37);
    endfunction

    // hold_reg masks tx_ready for one cycle after every strobe.
    logic can_issue;
    assign can_issue = bus.uart_tx_ready && !hold_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            word_reg     <= '0;
            prefix_reg   <= '0;
            count_reg    <= '0;
            hold_reg     <= 1'b0;
            ack_reg      <= '0;
            new_byte_reg <= 1'b0;
            byte_reg     <= '0;
            busy_reg     <= 1'b0;
            grant_reg    <= IDX_W'(NUM_SRC - 1);
        end else begin
            ack_reg      <= '0;
            new_byte_reg <= 1'b0;
            hold_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        word_reg   <= sel_word;
                        prefix_reg <= prefix_arr[win_idx];
                        count_reg  <= sel_count;
                        ack_reg    <= {{(NUM_SRC-1){1'b0}}, 1'b1} << win_idx;
                        grant_reg  <= win_idx;
                        busy_reg   <= 1'b1;
                        state_reg  <= (prefix_arr[win_idx] != 8'h00) ? PREFIX : DIGITS;
                    end
                end
                PREFIX: begin
                    if (can_issue) begin
                        new_byte_reg <= 1'b1;
                        byte_reg     <= prefix_reg;
                        hold_reg     <= 1'b1;
                        state_reg    <= DIGITS;
                    end
                end
                DIGITS: begin
                    if (can_issue) begin
                        new_byte_reg <= 1'b1;
                        byte_reg     <= hex_ascii(word_reg[31:28]);
                        hold_reg     <= 1'b1;
                        word_reg     <= {word_reg[27:0], 4'h0};
                        count_reg    <= count_reg - 4'd1;
                        if (count_reg == 4'd1) begin
                            state_reg <= NEWLINE;
                        end
                    end
                end
                NEWLINE: begin
                    if (can_issue) begin
                        new_byte_reg <= 1'b1;
                        byte_reg     <= 8'h0A;
                        hold_reg     <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.src_ack          = ack_reg;
    assign bus.uart_tx_new_byte = new_byte_reg;
    assign bus.uart_tx_byte     = byte_reg;
    assign busy                 = busy_reg;
    assign grant_idx            = grant_reg;

endmodule

// File: tb/tb_comm_tx_scheduler.sv
// Bench for comm_tx_scheduler: queue-driven sources, a transmitter ready model, a
// transaction-level line model checked every cycle, and literal line expectations.
module tb_comm_tx_scheduler;
    localparam int NUM_SRC = 3;
    localparam int IDX_W   = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  digits;
        logic [7:0]  prefix;
    } ent_t;

    logic             clk;
    logic             reset;
    logic             busy;
    logic [IDX_W-1:0] grant_idx;

    comm_tx_scheduler_if #(.NUM_SRC(NUM_SRC)) bus ();

    comm_tx_scheduler #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         total = 0;
    int         bad   = 0;
    ent_t       srcq [NUM_SRC][$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    logic [7:0] exp_log[$];
    int         glog[$];
    int         exp_glog[$];
    bit         stall_mode = 1'b0;
    int         stall_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sources present the head of their queue and move on the cycle after ack.
    initial begin : src_proc
        logic [NUM_SRC-1:0]    v;
        logic [32*NUM_SRC-1:0] d;
        logic [4*NUM_SRC-1:0]  g;
        logic [8*NUM_SRC-1:0]  p;
        ent_t                  dmy;
        bus.src_valid  = '0;
        bus.src_data   = '0;
        bus.src_digits = '0;
        bus.src_prefix = '0;
        forever begin
            @(posedge clk);
            #1;
            v = '0; d = '0; g = '0; p = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.src_ack[i] && srcq[i].size() > 0) dmy = srcq[i].pop_front();
                if (srcq[i].size() > 0) begin
                    v[i]          = 1'b1;
                    d[32*i +: 32] = srcq[i][0].data;
                    g[4*i +: 4]   = srcq[i][0].digits;
                    p[8*i +: 8]   = srcq[i][0].prefix;
                end
            end
            bus.src_valid  = v;
            bus.src_data   = d;
            bus.src_digits = g;
            bus.src_prefix = p;
        end
    end

    // Transmitter: always ready, or in stall mode busy for 100 cycles per strobe.
    initial begin : tx_proc
        bus.uart_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                if (bus.uart_tx_new_byte) begin
                    bus.uart_tx_ready = 1'b0;
                    stall_cnt = 100;
                end else if (stall_cnt > 0) begin
                    stall_cnt--;
                    if (stall_cnt == 0) bus.uart_tx_ready = 1'b1;
                end
            end else begin
                bus.uart_tx_ready = 1'b1;
            end
        end
    end

    function automatic void build_line(input ent_t e);
        int         n;
        logic [3:0] nib;
        n = (e.digits == 4'd0 || e.digits > 4'd8) ? 8 : int'(e.digits);
        if (e.prefix != 8'h00) exp_q.push_back(e.prefix);
        for (int k = n - 1; k >= 0; k--) begin
            nib = 4'((e.data >> (4 * k)) & 32'hF);
            exp_q.push_back((nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib}));
        end
        exp_q.push_back(8'h0A);
    endfunction

    logic [NUM_SRC-1:0]    valid_prev;
    logic [32*NUM_SRC-1:0] data_prev;
    logic [4*NUM_SRC-1:0]  digits_prev;
    logic [8*NUM_SRC-1:0]  prefix_prev;
    logic                  ready_prev;
    logic                  strobe_prev;
    int                    last_grant;

    // Cycle checker: a line is owed from its grant until its newline strobe.
    initial begin : cmp_proc
        bit                 q_busy;
        logic               exp_strobe;
        logic [7:0]         b;
        logic [NUM_SRC-1:0] exp_ack;
        int                 win;
        int                 c;
        ent_t               e;
        last_grant  = NUM_SRC - 1;
        valid_prev  = '0;
        data_prev   = '0;
        digits_prev = '0;
        prefix_prev = '0;
        ready_prev  = 1'b0;
        strobe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_ack", bus.src_ack, 0);
                chk("rst_strobe", bus.uart_tx_new_byte, 0);
                chk("rst_byte", bus.uart_tx_byte, 0);
                chk("rst_busy", busy, 0);
                chk("rst_grant", grant_idx, NUM_SRC - 1);
                exp_q.delete();
                last_grant  = NUM_SRC - 1;
                strobe_prev = 1'b0;
            end else begin
                q_busy     = exp_q.size() > 0;
                exp_strobe = q_busy && ready_prev && !strobe_prev;
                chk("strobe", bus.uart_tx_new_byte, exp_strobe);
                if (bus.uart_tx_new_byte) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL byte_extra: got %0h expected no byte at %0t", bus.uart_tx_byte, $time);
                    end else begin
                        b = exp_q.pop_front();
                        chk("byte", bus.uart_tx_byte, b);
                    end
                    rx_log.push_back(bus.uart_tx_byte);
                end
                exp_ack = '0;
                win     = -1;
                if (!q_busy && valid_prev != '0) begin
                    for (int k = 1; k <= NUM_SRC; k++) begin
                        c = (last_grant + k) % NUM_SRC;
                        if (win < 0 && valid_prev[c]) win = c;
                    end
                    exp_ack[win] = 1'b1;
                end
                chk("ack", bus.src_ack, exp_ack);
                if (win >= 0) begin
                    e.data   = data_prev[32*win +: 32];
                    e.digits = digits_prev[4*win +: 4];
                    e.prefix = prefix_prev[8*win +: 8];
                    build_line(e);
                    last_grant = win;
                    glog.push_back(win);
                end
                chk("busy", busy, exp_q.size() > 0);
                chk("grant_idx", grant_idx, last_grant);
                strobe_prev = bus.uart_tx_new_byte;
            end
            ready_prev  = bus.uart_tx_ready;
            valid_prev  = bus.src_valid;
            data_prev   = bus.src_data;
            digits_prev = bus.src_digits;
            prefix_prev = bus.src_prefix;
        end
    end

    task automatic push(input int s, input logic [31:0] d, input logic [3:0] g, input logic [7:0] p);
        ent_t e;
        e.data = d; e.digits = g; e.prefix = p;
        srcq[s].push_back(e);
    endtask

    function automatic bit all_idle();
        bit r;
        r = (busy == 1'b0) && (exp_q.size() == 0);
        for (int i = 0; i < NUM_SRC; i++) if (srcq[i].size() > 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        bit idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < max_cyc) begin
            @(negedge clk);
            #1;
            idle = all_idle();
            n++;
        end
        chk({name, "_finished"}, idle, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_logs(input string name);
        chk({name, "_nbytes"}, rx_log.size(), exp_log.size());
        for (int i = 0; i < rx_log.size() && i < exp_log.size(); i++)
            chk({name, "_line_byte"}, rx_log[i], exp_log[i]);
        chk({name, "_ngrants"}, glog.size(), exp_glog.size());
        for (int i = 0; i < glog.size() && i < exp_glog.size(); i++)
            chk({name, "_grant_order"}, glog[i], exp_glog[i]);
        rx_log.delete();
        glog.delete();
    endtask

    task automatic async_reset_check(input string name);
        #1 reset = 1'b1;
        #1;
        chk({name, "_async_strobe"}, bus.uart_tx_new_byte, 0);
        chk({name, "_async_byte"}, bus.uart_tx_byte, 0);
        chk({name, "_async_busy"}, busy, 0);
        chk({name, "_async_ack"}, bus.src_ack, 0);
        chk({name, "_async_grant"}, grant_idx, 2);
        rx_log.delete();
        glog.delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_grant", grant_idx, 2);
        chk("init_strobe", bus.uart_tx_new_byte, 0);
        #1 reset = 1'b0;

        // Plain 8-digit word, no prefix.
        @(negedge clk); #1;
        push(0, 32'hDEADBEEF, 4'd8, 8'h00);
        wait_idle("deadbeef", 500);
        exp_log  = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
        exp_glog = '{0};
        check_logs("deadbeef");

        // Prefixed 4-digit word; leading zeros suppressed.
        @(negedge clk); #1;
        push(1, 32'h00002A5C, 4'd4, 8'h54);
        wait_idle("prefix_t", 500);
        exp_log  = '{8'h54, 8'h32, 8'h41, 8'h35, 8'h43, 8'h0A};
        exp_glog = '{1};
        check_logs("prefix_t");

        // Round-robin fairness from reset priority.
        @(negedge clk);
        async_reset_check("rr_pre");
        @(negedge clk); #1;
        push(0, 32'h000000A0, 4'd2, 8'h00);
        push(1, 32'h000000B1, 4'd2, 8'h00);
        push(2, 32'h000000C2, 4'd2, 8'h00);
        push(0, 32'h000000D3, 4'd2, 8'h00);
        push(1, 32'h000000E4, 4'd2, 8'h00);
        wait_idle("round_robin", 500);
        exp_log  = '{8'h41, 8'h30, 8'h0A, 8'h42, 8'h31, 8'h0A, 8'h43, 8'h32, 8'h0A,
                     8'h44, 8'h33, 8'h0A, 8'h45, 8'h34, 8'h0A};
        exp_glog = '{0, 1, 2, 0, 1};
        check_logs("round_robin");

        // Slow transmitter: 100-cycle busy window after every strobe.
        stall_mode = 1'b1;
        @(negedge clk); #1;
        push(2, 32'h13579BDF, 4'd8, 8'h4E);
        wait_idle("stall", 3000);
        exp_log  = '{8'h4E, 8'h31, 8'h33, 8'h35, 8'h37, 8'h39, 8'h42, 8'h44, 8'h46, 8'h0A};
        exp_glog = '{2};
        check_logs("stall");
        stall_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Digit count 0 means 8; 15 clamps to 8.
        @(negedge clk); #1;
        push(0, 32'h0123ABCF, 4'd0, 8'h00);
        push(0, 32'h0123ABCF, 4'hF, 8'h00);
        wait_idle("digits_clamp", 500);
        exp_log  = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h46, 8'h0A,
                     8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h46, 8'h0A};
        exp_glog = '{0, 0};
        check_logs("digits_clamp");

        // Reset after three digits; the still-valid source restarts a full line.
        @(negedge clk); #1;
        push(0, 32'hDEADBEEF, 4'd8, 8'h00);
        push(0, 32'hDEADBEEF, 4'd8, 8'h00);
        n = 0;
        while (rx_log.size() < 3 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("midline_three_digits", rx_log.size(), 3);
        async_reset_check("midline");
        wait_idle("after_reset", 500);
        exp_log  = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
        exp_glog = '{0};
        check_logs("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
